// File: rtl/instr_fetch_queue.sv
// Fetch stage: tracks the fetch PC, gates imem requests on FIFO space and buffers {pc, word} pairs.
// Define IFETCH_BYPASS_EN to forward a response straight to the core when the FIFO is empty.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_inflight_pc;
    logic             r_inflight;
    logic [31:0]      r_mem_data [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic             r_instr_valid;

    logic             w_resp;
    logic             w_bypass;
    logic             w_valid;
    logic             w_pop_any;
    logic             w_fifo_pop;
    logic             w_push;
    logic             w_req;
    logic [CNT_W:0]   w_occ;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [31:0]      w_head_data;
    logic [31:0]      w_head_pc;
    logic             w_unused;

    assign w_unused = ^redirect_pc[1:0];

    // A response arriving in a redirect cycle belongs to the old stream and is dropped.
    assign w_resp = r_inflight & ~redirect;
`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_resp & (r_count == {CNT_W{1'b0}});
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid    = r_instr_valid | w_bypass;
    assign w_pop_any  = w_valid & instr_ready;
    assign w_fifo_pop = r_instr_valid & instr_ready;
    assign w_push     = w_resp & ~(w_bypass & instr_ready);

    // Occupancy after this cycle, counting the response already on its way back.
    assign w_occ = {1'b0, r_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop_any);
    assign w_req = (r_state != IDLE) & ~redirect & (w_occ < (CNT_W+1)'(DEPTH));

    // Next FIFO count/read pointer and the entry that becomes the head.
    always_comb begin
        w_count_nxt  = r_count;
        w_rd_ptr_nxt = r_rd_ptr;
        w_head_data  = 32'h0000_0000;
        w_head_pc    = 32'h0000_0000;
        if (redirect) begin
            w_count_nxt  = {CNT_W{1'b0}};
            w_rd_ptr_nxt = {PTR_W{1'b0}};
        end else begin
            w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_fifo_pop);
        end
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_data = imem_rdata;
            w_head_pc   = r_inflight_pc;
        end else begin
            w_head_data = r_mem_data[w_rd_ptr_nxt];
            w_head_pc   = r_mem_pc[w_rd_ptr_nxt];
        end
    end

    // FSM: IDLE -> RUN after reset; any redirect (re)starts a one-cycle FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     r_state <= redirect ? FLUSH : RUN;
                FLUSH:   r_state <= redirect ? FLUSH : RUN;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Fetch PC and in-flight request tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
        end else begin
            r_inflight    <= w_req;
            r_inflight_pc <= r_fetch_pc;
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_count  <= w_count_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (redirect) begin
                r_wr_ptr <= {PTR_W{1'b0}};
            end else if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
        end
    end

    // Registered head; holds its last value while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr       <= 32'h0000_0000;
            r_instr_pc    <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= (w_count_nxt != {CNT_W{1'b0}});
            if (w_count_nxt != {CNT_W{1'b0}}) begin
                r_instr    <= w_head_data;
                r_instr_pc <= w_head_pc;
            end else if (w_bypass && instr_ready) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_inflight_pc;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc[ADDR_W+1:2];
    assign instr       = w_bypass ? imem_rdata : r_instr;
    assign instr_pc    = w_bypass ? r_inflight_pc : r_instr_pc;
    assign instr_valid = w_valid;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus a random phase against a sequential-stream model.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = 32'h0000_0000;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    int          total = 0;
    int          bad   = 0;
    int          nreq  = 0;
    int          occ   = 0;
    logic [31:0] exp_pc;

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word k holds A000_0000 + k.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 + {24'h0, imem_addr};
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'hA000_0000 + {24'h0, pc[9:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Model step: every accepted word continues the sequential stream; redirect/reset restart it.
    task automatic fin();
        if (rst) begin
            exp_pc = RESET_PC;
            occ    = 0;
        end else begin
            if (instr_valid && instr_ready) begin
                chk("hs_pc", instr_pc, exp_pc);
                chk("hs_instr", instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                occ    = occ - 1;
            end
            if (imem_req) occ = occ + 1;
            chk("occ_le_depth", {31'h0, (occ <= DEPTH)}, 32'd1);
            if (redirect) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                occ    = 0;
            end
        end
        if (imem_req) nreq++;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        mid();
        fin();
    endtask

    // From the cycle after the first request: valid rises exactly LAT cycles later with this pc.
    task automatic expect_first(input logic [31:0] pc);
        for (int k = 1; k < LAT; k++) begin
            mid(); chk("lat_wait_valid", {31'h0, instr_valid}, 32'd0); fin();
        end
        mid();
        chk("first_valid", {31'h0, instr_valid}, 32'd1);
        chk("first_pc", instr_pc, pc);
        fin();
    endtask

    // Cycle after a redirect: empty head, request at the new PC, then first delivery.
    task automatic post_redirect(input logic [31:0] pc);
        mid();
        chk("rd_valid0", {31'h0, instr_valid}, 32'd0);
        chk("rd_req", {31'h0, imem_req}, 32'd1);
        chk("rd_addr", {24'h0, imem_addr}, {24'h0, pc[9:2]});
        fin();
        expect_first(pc);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
        exp_pc = RESET_PC;
        repeat (2) cyc();
        mid();
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h40);
        chk("rst_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        fin();

        // Start-up stream from RESET_PC at one word per cycle.
        rst = 1'b0;
        mid(); chk("idle_req", {31'h0, imem_req}, 32'd0); fin();
        mid();
        chk("first_req", {31'h0, imem_req}, 32'd1);
        chk("first_addr", {24'h0, imem_addr}, 32'h40);
        fin();
        expect_first(32'h100);
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("stream_valid", {31'h0, instr_valid}, 32'd1);
            chk("stream_pc", instr_pc, 32'h104 + 32'(4 * k));
            chk("stream_addr", {24'h0, imem_addr}, 32'(32'h41 + LAT + k));
            fin();
        end

        // Back-pressure: exactly DEPTH words fetched, then a gap-free drain.
        redirect = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
        cyc();
        redirect = 1'b0; nreq = 0;
        repeat (10) cyc();
        mid();
        chk("full_req", {31'h0, imem_req}, 32'd0);
        chk("full_nreq", nreq, DEPTH);
        chk("full_valid", {31'h0, instr_valid}, 32'd1);
        chk("full_head", instr_pc, 32'h0);
        fin();
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("drain_valid", {31'h0, instr_valid}, 32'd1);
            chk("drain_pc", instr_pc, 32'(4 * k));
            fin();
        end

        // Redirect while 3 entries are buffered and a response is in flight.
        redirect = 1'b1; redirect_pc = 32'h1000; instr_ready = 1'b0;
        cyc();
        redirect = 1'b0;
        repeat (4) cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0203; instr_ready = 1'b1;
        mid(); chk("pre_rd_head", instr_pc, 32'h1000); fin();
        redirect = 1'b0;
        post_redirect(32'h200);
        repeat (3) cyc();

        // Back-to-back redirects: only the newer stream survives.
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect_pc = 32'h80;
        mid();
        chk("b2b_valid0", {31'h0, instr_valid}, 32'd0);
        chk("b2b_req0", {31'h0, imem_req}, 32'd0);
        fin();
        redirect = 1'b0;
        post_redirect(32'h80);
        repeat (3) cyc();

        // PC wrap at 2^32.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect = 1'b0;
        post_redirect(32'hFFFF_FFF8);
        mid(); chk("wrap_pc_fffc", instr_pc, 32'hFFFF_FFFC); fin();
        mid(); chk("wrap_pc_0", instr_pc, 32'h0); fin();
        mid(); chk("wrap_pc_4", instr_pc, 32'h4); fin();

        // Random ready/redirect traffic.
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            cyc();
        end
        redirect = 1'b0; instr_ready = 1'b1;
        repeat (6) cyc();

        // Asynchronous reset mid-stream, then restart at RESET_PC.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, instr_valid}, 32'd0);
        chk("arst_req", {31'h0, imem_req}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        mid(); chk("rst2_idle_req", {31'h0, imem_req}, 32'd0); fin();
        mid();
        chk("rst2_req", {31'h0, imem_req}, 32'd1);
        chk("rst2_addr", {24'h0, imem_addr}, 32'h40);
        fin();
        expect_first(32'h100);
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
